// File: rtl/hex_display_mux_if.sv
// Bus bundle for hex_display_mux: the value/strobe inputs from the datapath
// and the segment/anode pins plus status back to it.
interface hex_display_mux_if #(
    parameter int N_DIGITS = 4
);
    logic                    en;
    logic                    load;
    logic [4*N_DIGITS-1:0]   data;
    logic [N_DIGITS-1:0]     dp;
    logic [6:0]              seg;
    logic                    seg_dp;
    logic [N_DIGITS-1:0]     an;
    logic                    pending;
    logic                    frame;

    // Datapath side: drives the value to display, observes pins and status
    modport master (
        output en, load, data, dp,
        input  seg, seg_dp, an, pending, frame
    );

    // Display driver side
    modport slave (
        input  en, load, data, dp,
        output seg, seg_dp, an, pending, frame
    );
endinterface

// File: rtl/hex_display_mux.sv
// Time-multiplexed N-digit hex driver for common-cathode 7-segment displays.
// A loaded value waits in a pending register and is moved into the display
// register only at a frame boundary, so a frame never mixes old and new digits.
// Each digit slot starts with GUARD cycles of all anodes off to stop ghosting.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits
// (digit 0 always shown). Without it every digit is decoded.
module hex_display_mux #(
    parameter int N_DIGITS   = 4,
    parameter int SCAN_DIV   = 12500,
    parameter int GUARD      = 2,
    parameter int AN_ACT_LOW = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    hex_display_mux_if.slave bus
);

    localparam int PS_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int DW    = 4 * N_DIGITS;
    localparam logic [N_DIGITS-1:0] AN_OFF =
        (AN_ACT_LOW != 0) ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

    logic [PS_W-1:0]     prescaler_q, prescaler_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DW-1:0]       pend_data_q, pend_data_d;
    logic [N_DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic                pending_q, pending_d;
    logic [DW-1:0]       disp_data_q, disp_data_d;
    logic [N_DIGITS-1:0] disp_dp_q, disp_dp_d;
    logic [6:0]          seg_q, seg_d;
    logic                seg_dp_q, seg_dp_d;
    logic [N_DIGITS-1:0] an_q, an_d;
    logic                frame_q, frame_d;

    logic                tick;
    logic                last_digit;
    logic                boundary;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_blank;
    logic [N_DIGITS-1:0] cur_onehot;
    logic                in_guard;

    // Segment patterns for a common-cathode display, bit 0 = segment a
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Slot prescaler and digit index; a frame ends on the last digit's tick
    always_comb begin
        tick        = (prescaler_q == PS_W'(SCAN_DIV - 1));
        last_digit  = (idx_q == IDX_W'(N_DIGITS - 1));
        boundary    = tick && last_digit;
        prescaler_d = tick ? '0 : prescaler_q + 1'b1;
        idx_d       = idx_q;
        if (tick) begin
            idx_d = last_digit ? '0 : idx_q + 1'b1;
        end
        frame_d = boundary;
    end

    // Pending/display registers: the boundary moves the old pending value, a
    // coincident load lands in pending and waits for the following frame
    always_comb begin
        pend_data_d = pend_data_q;
        pend_dp_d   = pend_dp_q;
        pending_d   = pending_q;
        disp_data_d = disp_data_q;
        disp_dp_d   = disp_dp_q;
        if (boundary) begin
            if (pending_q) begin
                disp_data_d = pend_data_q;
                disp_dp_d   = pend_dp_q;
            end
            pending_d = 1'b0;
        end
        if (bus.load) begin
            pend_data_d = bus.data;
            pend_dp_d   = bus.dp;
            pending_d   = 1'b1;
        end
    end

    // Select the current digit, decode it and apply guard band / enable
    always_comb begin
        cur_nib    = '0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        cur_onehot = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib       = disp_data_q[4*i +: 4];
                cur_dp        = disp_dp_q[i];
                cur_onehot[i] = 1'b1;
            end
        end
`ifdef LEADING_ZERO_BLANK_EN
        begin
            logic zero_run;
            zero_run = 1'b1;
            for (int i = N_DIGITS - 1; i >= 1; i--) begin
                zero_run = zero_run && (disp_data_q[4*i +: 4] == 4'h0);
                if (idx_q == IDX_W'(i)) begin
                    cur_blank = zero_run;
                end
            end
        end
`endif
        in_guard = (prescaler_q < PS_W'(GUARD));
        seg_d    = '0;
        seg_dp_d = 1'b0;
        an_d     = AN_OFF;
        if (bus.en && !in_guard) begin
            an_d     = AN_OFF ^ cur_onehot;
            seg_d    = cur_blank ? 7'h00 : hex_to_seg(cur_nib);
            seg_dp_d = cur_dp;
        end
    end

    // State and registered pin outputs; reset blanks the display at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler_q <= '0;
            idx_q       <= '0;
            pend_data_q <= '0;
            pend_dp_q   <= '0;
            pending_q   <= 1'b0;
            disp_data_q <= '0;
            disp_dp_q   <= '0;
            seg_q       <= '0;
            seg_dp_q    <= 1'b0;
            an_q        <= AN_OFF;
            frame_q     <= 1'b0;
        end else begin
            prescaler_q <= prescaler_d;
            idx_q       <= idx_d;
            pend_data_q <= pend_data_d;
            pend_dp_q   <= pend_dp_d;
            pending_q   <= pending_d;
            disp_data_q <= disp_data_d;
            disp_dp_q   <= disp_dp_d;
            seg_q       <= seg_d;
            seg_dp_q    <= seg_dp_d;
            an_q        <= an_d;
            frame_q     <= frame_d;
        end
    end

    assign bus.seg     = seg_q;
    assign bus.seg_dp  = seg_dp_q;
    assign bus.an      = an_q;
    assign bus.pending = pending_q;
    assign bus.frame   = frame_q;

endmodule

// File: tb/tb_hex_display_mux.sv
// Bench for hex_display_mux (4 digits, 4-cycle slots, 1 guard cycle,
// active-low anodes). A cycle-count reference model predicts every output.
module tb_hex_display_mux;

    localparam int N       = 4;
    localparam int DIV     = 4;
    localparam int GRD     = 1;
    localparam int ACT_LOW = 1;
    localparam int FRAME   = N * DIV;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    logic check_en = 1'b0;

    always #5 clk = ~clk;

    hex_display_mux_if #(.N_DIGITS(N)) bus_if ();

    hex_display_mux #(
        .N_DIGITS  (N),
        .SCAN_DIV  (DIV),
        .GUARD     (GRD),
        .AN_ACT_LOW(ACT_LOW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    logic [6:0] seg_table [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                     7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model state: cycles since reset release plus value registers
    int         m_cnt;
    logic [15:0] m_pend_data, m_disp_data;
    logic [3:0]  m_pend_dp, m_disp_dp;
    logic        m_pending;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic [3:0]  exp_an;
    logic        exp_frame;

    function automatic logic [3:0] model_an(input int cnt, input logic on);
        int slot;
        int digit;
        logic [3:0] oh;
        slot  = cnt % DIV;
        digit = (cnt / DIV) % N;
        if (!on || slot < GRD) return 4'hF;
        oh = 4'(1 << digit);
        return ~oh;
    endfunction

    function automatic logic [6:0] model_seg(input int cnt, input logic on, input logic [15:0] v);
        int slot;
        int digit;
        logic [15:0] upper;
        slot  = cnt % DIV;
        digit = (cnt / DIV) % N;
        if (!on || slot < GRD) return 7'h00;
        upper = v >> (4 * digit);
`ifdef LEADING_ZERO_BLANK_EN
        if (digit > 0 && upper == 16'h0) return 7'h00;
`endif
        return seg_table[upper[3:0]];
    endfunction

    function automatic logic model_dp(input int cnt, input logic on, input logic [3:0] p);
        int slot;
        int digit;
        slot  = cnt % DIV;
        digit = (cnt / DIV) % N;
        if (!on || slot < GRD) return 1'b0;
        return p[digit];
    endfunction

    // Model update: outputs follow the pre-edge count, values move at frame ends
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt       <= 0;
            m_pend_data <= '0;
            m_pend_dp   <= '0;
            m_disp_data <= '0;
            m_disp_dp   <= '0;
            m_pending   <= 1'b0;
            exp_seg     <= '0;
            exp_dp      <= 1'b0;
            exp_an      <= 4'hF;
            exp_frame   <= 1'b0;
        end else begin
            exp_seg   <= model_seg(m_cnt, bus_if.en, m_disp_data);
            exp_dp    <= model_dp(m_cnt, bus_if.en, m_disp_dp);
            exp_an    <= model_an(m_cnt, bus_if.en);
            exp_frame <= (m_cnt % FRAME == FRAME - 1);
            m_cnt     <= m_cnt + 1;
            if (bus_if.load) begin
                m_pend_data <= bus_if.data;
                m_pend_dp   <= bus_if.dp;
                m_pending   <= 1'b1;
            end else if (m_cnt % FRAME == FRAME - 1) begin
                m_pending <= 1'b0;
            end
            if ((m_cnt % FRAME == FRAME - 1) && m_pending) begin
                m_disp_data <= m_pend_data;
                m_disp_dp   <= m_pend_dp;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkTimeout(input string tag, input logic found);
        checks++;
        assert (found)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=timeout expected=event", tag);
        end
    endtask

    // Every cycle, compare all pins against the model away from the clock edge
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("seg", {9'd0, bus_if.seg}, {9'd0, exp_seg});
            checkOutput("seg_dp", {15'd0, bus_if.seg_dp}, {15'd0, exp_dp});
            checkOutput("an", {12'd0, bus_if.an}, {12'd0, exp_an});
            checkOutput("pending", {15'd0, bus_if.pending}, {15'd0, m_pending});
            checkOutput("frame", {15'd0, bus_if.frame}, {15'd0, exp_frame});
        end
    end

    task automatic applyStimulus(input logic en, input logic ld,
                                 input logic [15:0] d, input logic [3:0] p);
        @(negedge clk);
        bus_if.en   = en;
        bus_if.load = ld;
        bus_if.data = d;
        bus_if.dp   = p;
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p);
        applyStimulus(1'b1, 1'b1, d, p);
        applyStimulus(1'b1, 1'b0, d, p);
    endtask

    task automatic wait_frame(input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 4 * FRAME && !found; i++) begin
            @(negedge clk);
            if (bus_if.frame === 1'b1) found = 1'b1;
        end
        checkTimeout(tag, found);
    endtask

    initial begin
        logic [6:0] digit_seg [4];
        logic found;

        rst_n         = 1'b1;
        bus_if.en     = 1'b1;
        bus_if.load   = 1'b0;
        bus_if.data   = '0;
        bus_if.dp     = '0;
        #1 rst_n = 1'b0;
        check_en = 1'b1;

        // Step 1: reset state, then anode scan order with guard cycles
        repeat (10) @(negedge clk);
        checkOutput("rst_seg", {9'd0, bus_if.seg}, 16'h0000);
        checkOutput("rst_an", {12'd0, bus_if.an}, 16'h000F);
        checkOutput("rst_pending", {15'd0, bus_if.pending}, 16'h0000);
        rst_n = 1'b1;
        for (int d = 0; d < N; d++) begin
            @(negedge clk);
            checkOutput("scan_guard_an", {12'd0, bus_if.an}, 16'h000F);
            repeat (DIV - GRD) begin
                @(negedge clk);
                checkOutput("scan_an", {12'd0, bus_if.an}, {12'd0, ~(4'b0001 << d)});
            end
        end

        // Step 2: tear-free load of 3A7F with dp on digit 2
        do_load(16'h3A7F, 4'b0100);
        checkOutput("load_pending", {15'd0, bus_if.pending}, 16'h0001);
        wait_frame("frame_after_load");
        checkOutput("pending_cleared", {15'd0, bus_if.pending}, 16'h0000);
        digit_seg = '{7'h71, 7'h07, 7'h77, 7'h4F};
        for (int d = 0; d < N; d++) begin
            repeat (d == 0 ? 2 : DIV) @(negedge clk);
            checkOutput("digit_seg", {9'd0, bus_if.seg}, {9'd0, digit_seg[d]});
            checkOutput("digit_dp", {15'd0, bus_if.seg_dp}, {15'd0, (d == 2)});
        end

        // Step 3: two loads within one frame, last one wins
        do_load(16'h1111, 4'b0000);
        do_load(16'h2222, 4'b0000);
        wait_frame("frame_after_double_load");
        repeat (2) @(negedge clk);
        checkOutput("last_wins_seg", {9'd0, bus_if.seg}, 16'h005B);

        // Step 4: load exactly on the boundary cycle
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            @(negedge clk);
            if (m_cnt % FRAME == FRAME - 1) found = 1'b1;
        end
        checkTimeout("find_boundary", found);
        bus_if.load = 1'b1;
        bus_if.data = 16'hBEEF;
        bus_if.dp   = 4'b0001;
        @(negedge clk);
        bus_if.load = 1'b0;
        checkOutput("boundary_frame", {15'd0, bus_if.frame}, 16'h0001);
        checkOutput("boundary_pending", {15'd0, bus_if.pending}, 16'h0001);
        repeat (2) @(negedge clk);
        checkOutput("old_value_kept", {9'd0, bus_if.seg}, 16'h005B);
        wait_frame("frame_for_beef");
        repeat (2) @(negedge clk);
        checkOutput("beef_digit0", {9'd0, bus_if.seg}, 16'h0071);

        // Step 5: leading zeros of 0005
        do_load(16'h0005, 4'b0000);
        wait_frame("frame_for_0005");
        repeat (2) @(negedge clk);
        checkOutput("zero5_digit0", {9'd0, bus_if.seg}, 16'h006D);
        repeat (DIV) @(negedge clk);
`ifdef LEADING_ZERO_BLANK_EN
        checkOutput("zero5_digit1", {9'd0, bus_if.seg}, 16'h0000);
`else
        checkOutput("zero5_digit1", {9'd0, bus_if.seg}, 16'h003F);
`endif

        // Step 6: enable off mid-frame, then back on
        repeat (3) @(negedge clk);
        bus_if.en = 1'b0;
        @(negedge clk);
        checkOutput("en_off_an", {12'd0, bus_if.an}, 16'h000F);
        checkOutput("en_off_seg", {9'd0, bus_if.seg}, 16'h0000);
        repeat (5) @(negedge clk);
        bus_if.en = 1'b1;
        repeat (2 * FRAME) @(negedge clk);

        // Randomized traffic: loads, enable toggles, values and decimal points
        for (int i = 0; i < 300; i++) begin
            applyStimulus(($urandom % 8) != 0, ($urandom % 6) == 0,
                          16'($urandom), 4'($urandom));
        end
        applyStimulus(1'b1, 1'b0, 16'h0, 4'h0);
        repeat (2 * FRAME) @(negedge clk);

        // Reset in the middle of a slot blanks asynchronously
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 checkOutput("async_rst_an", {12'd0, bus_if.an}, 16'h000F);
        checkOutput("async_rst_seg", {9'd0, bus_if.seg}, 16'h0000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("restart_an", {12'd0, bus_if.an}, 16'h000E);
        checkOutput("restart_seg", {9'd0, bus_if.seg}, 16'h003F);
        repeat (FRAME) @(negedge clk);

        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
